// File: rtl/scan_pkg.sv
// Shared step codes and state encoding for the macroblock frame-scan controller.
package scan_pkg;

    localparam logic [1:0] X_SUB16 = 2'b00;
    localparam logic [1:0] X_HOLD  = 2'b01;
    localparam logic [1:0] X_ADD4  = 2'b10;
    localparam logic [1:0] X_ADD16 = 2'b11;

    localparam logic [1:0] Y_SUB16 = 2'b00;
    localparam logic [1:0] Y_HOLD  = 2'b01;
    localparam logic [1:0] Y_ADD1  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        ROW_RET = 3'd2,
        MB_NEXT = 3'd3,
        END_COL = 3'd4,
        REWIND  = 3'd5,
        DONE    = 3'd6
    } scan_state_t;

endpackage

// File: rtl/mb_scan_ctrl.sv
// Macroblock raster-scan controller: steps the datapath x/y pointer and issues word fetches.
// Optional SCAN_CHECK_EN adds a sticky chk_err output for datapath alignment/stop checks.
module mb_scan_ctrl
    import scan_pkg::*;
#(
    parameter  int unsigned WIDTH   = 352,
    parameter  int unsigned HEIGHT  = 288,
    localparam int unsigned MB_COLS = WIDTH / 16,
    localparam int unsigned MB_ROWS = HEIGHT / 16,
    localparam int unsigned COL_W   = (MB_COLS > 1) ? $clog2(MB_COLS) : 1,
    localparam int unsigned ROW_W   = (MB_ROWS > 1) ? $clog2(MB_ROWS) : 1,
    localparam int unsigned REW_W   = $clog2(MB_COLS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             x_16,
    input  logic             y_16,
    output logic [1:0]       x_count,
    output logic [1:0]       y_count,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [1:0]       req_word,
    output logic [3:0]       req_row,
    output logic [COL_W-1:0] mb_col,
    output logic [ROW_W-1:0] mb_row,
    output logic             busy,
`ifdef SCAN_CHECK_EN
    output logic             chk_err,
`endif
    output logic             done
);

    scan_state_t      r_state;
    scan_state_t      w_next;
    logic [1:0]       r_word;
    logic [3:0]       r_row;
    logic [COL_W-1:0] r_mb_col;
    logic [ROW_W-1:0] r_mb_row;
    logic [REW_W-1:0] r_rew_cnt;

    logic w_accept;
    logic w_last_word;
    logic w_last_line;
    logic w_last_col;
    logic w_last_row;
    logic w_rew_last;

    assign w_accept    = (r_state == FETCH) && req_ready;
    assign w_last_word = (r_word == 2'd3);
    assign w_last_line = (r_row == 4'd15);
    assign w_last_col  = (r_mb_col == COL_W'(MB_COLS - 1));
    assign w_last_row  = (r_mb_row == ROW_W'(MB_ROWS - 1));
    assign w_rew_last  = (r_rew_cnt == REW_W'(MB_COLS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FETCH;
            FETCH:   if (w_accept && w_last_word) w_next = ROW_RET;
            ROW_RET: begin
                if (!w_last_line)     w_next = FETCH;
                else if (!w_last_col) w_next = MB_NEXT;
                else                  w_next = END_COL;
            end
            MB_NEXT: w_next = FETCH;
            END_COL: w_next = w_last_row ? DONE : REWIND;
            REWIND:  if (w_rew_last) w_next = FETCH;
            DONE:    if (stop) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Step codes and handshake outputs, decoded from the current state
    always_comb begin
        x_count   = X_HOLD;
        y_count   = Y_HOLD;
        req_valid = 1'b0;
        done      = 1'b0;
        case (r_state)
            FETCH: begin
                req_valid = 1'b1;
                if (req_ready) x_count = X_ADD4;
            end
            ROW_RET: begin
                x_count = X_SUB16;
                y_count = Y_ADD1;
            end
            MB_NEXT: begin
                x_count = X_ADD16;
                y_count = Y_SUB16;
            end
            END_COL: x_count = X_ADD16;
            REWIND:  x_count = X_SUB16;
            DONE:    done    = stop;
            default: ;
        endcase
    end

    // Scan position counters, advanced only on FSM transitions
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word    <= '0;
            r_row     <= '0;
            r_mb_col  <= '0;
            r_mb_row  <= '0;
            r_rew_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_word    <= '0;
                    r_row     <= '0;
                    r_mb_col  <= '0;
                    r_mb_row  <= '0;
                    r_rew_cnt <= '0;
                end
                FETCH:   if (w_accept) r_word <= w_last_word ? 2'd0 : r_word + 2'd1;
                ROW_RET: r_row <= w_last_line ? 4'd0 : r_row + 4'd1;
                MB_NEXT: r_mb_col <= r_mb_col + COL_W'(1);
                END_COL: if (!w_last_row) begin
                    r_mb_row  <= r_mb_row + ROW_W'(1);
                    r_mb_col  <= '0;
                    r_rew_cnt <= '0;
                end
                REWIND:  r_rew_cnt <= w_rew_last ? '0 : r_rew_cnt + REW_W'(1);
                default: ;
            endcase
        end
    end

    assign req_word = r_word;
    assign req_row  = r_row;
    assign mb_col   = r_mb_col;
    assign mb_row   = r_mb_row;
    assign busy     = (r_state != IDLE);

`ifdef SCAN_CHECK_EN
    logic r_chk_err;
    logic w_chk_hit;

    // Misaligned pointer at a word-0 fetch, or datapath claiming end-of-frame mid-scan
    assign w_chk_hit = ((r_state == FETCH) && (r_word == 2'd0) && !x_16)
                    || ((r_state == FETCH) && (r_word == 2'd0) && (r_row == 4'd0) && !y_16)
                    || (stop && (r_state != IDLE) && (r_state != DONE));

    always_ff @(posedge clk) begin
        if (reset)          r_chk_err <= 1'b0;
        else if (w_chk_hit) r_chk_err <= 1'b1;
    end

    assign chk_err = r_chk_err;
`else
    logic w_unused_align;
    assign w_unused_align = x_16 ^ y_16;
`endif

endmodule

// File: tb/tb_mb_scan_ctrl.sv
// Self-checking bench for mb_scan_ctrl on a 32x32 frame with a behavioural x/y datapath model.
module tb_mb_scan_ctrl;

    localparam int W = 32;
    localparam int H = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       x_16;
    logic       y_16;
    logic [1:0] x_count;
    logic [1:0] y_count;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_word;
    logic [3:0] req_row;
    logic       mb_col;
    logic       mb_row;
    logic       busy;
    logic       done;
`ifdef SCAN_CHECK_EN
    logic       chk_err;
`endif

    int   x;
    int   y;
    logic force_x16;
    int   n_checks;
    int   n_fail;

    typedef struct {
        int mr;
        int mc;
        int row;
        int word;
    } hs_t;

    hs_t exp_q[$];

    mb_scan_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .x_16      (x_16),
        .y_16      (y_16),
        .x_count   (x_count),
        .y_count   (y_count),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_word  (req_word),
        .req_row   (req_row),
        .mb_col    (mb_col),
        .mb_row    (mb_row),
        .busy      (busy),
`ifdef SCAN_CHECK_EN
        .chk_err   (chk_err),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    // Datapath pointer: applies the step codes at each clock edge
    always @(posedge clk) begin
        if (reset) begin
            x <= 0;
            y <= 0;
        end else begin
            case (x_count)
                2'b00:   x <= x - 16;
                2'b10:   x <= x + 4;
                2'b11:   x <= x + 16;
                default: x <= x;
            endcase
            case (y_count)
                2'b00:   y <= y - 16;
                2'b11:   y <= y + 1;
                default: y <= y;
            endcase
        end
    end

    assign stop = (x == W) && (y == H);
    assign x_16 = !force_x16 && ((x % 16) == 0);
    assign y_16 = ((y % 16) == 0);

    // Raster order: macroblock rows, macroblock columns, pixel rows, words
    task automatic build_expected();
        hs_t e;
        exp_q.delete();
        for (int mr = 0; mr < H / 16; mr++)
            for (int mc = 0; mc < W / 16; mc++)
                for (int row = 0; row < 16; row++)
                    for (int w = 0; w < 4; w++) begin
                        e.mr = mr; e.mc = mc; e.row = row; e.word = w;
                        exp_q.push_back(e);
                    end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; req_ready = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b, required 0 0 0", req_valid, busy, done);
        end
        n_checks++;
        if (x_count !== 2'b01 || y_count !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_codes: x_count=%b y_count=%b, required 01 01", x_count, y_count);
        end
        n_checks++;
        if (req_word !== 2'd0 || req_row !== 4'd0 || mb_col !== 1'b0 || mb_row !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idx: word=%0d row=%0d col=%0d mbrow=%0d, required all 0",
                     req_word, req_row, mb_col, mb_row);
        end
        n_checks++;
        if (x !== 0 || y !== 0) begin
            n_fail++;
            $display("FAIL reset_xy: x=%0d y=%0d, required 0 0", x, y);
        end
`ifdef SCAN_CHECK_EN
        n_checks++;
        if (chk_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_chk: chk_err=%b, required 0", chk_err);
        end
`endif
        reset = 1'b0;
    endtask

    // Full frame scan; stall selects random 1-in-3 ready plus stray start pulses
    task automatic test_scan(input bit stall);
        hs_t e;
        int  hs = 0;
        int  c = 0;
        int  done_c = -1;
        build_expected();
        @(negedge clk);
        start = 1'b1; req_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (done_c < 0 && c < 3000) begin
            req_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            start     = stall ? ($urandom_range(0, 15) == 0) : 1'b0;
            #1;
            if (req_valid && req_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL hs_extra: handshake %0d beyond 256 expected", hs);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(mb_row) !== e.mr || int'(mb_col) !== e.mc ||
                        int'(req_row) !== e.row || int'(req_word) !== e.word) begin
                        n_fail++;
                        $display("FAIL hs_idx %0d: mbrow=%0d mbcol=%0d row=%0d word=%0d, required %0d %0d %0d %0d",
                                 hs, mb_row, mb_col, req_row, req_word, e.mr, e.mc, e.row, e.word);
                    end
                    n_checks++;
                    if (x !== e.mc * 16 + e.word * 4 || y !== e.mr * 16 + e.row) begin
                        n_fail++;
                        $display("FAIL hs_xy %0d: x=%0d y=%0d, required %0d %0d",
                                 hs, x, y, e.mc * 16 + e.word * 4, e.mr * 16 + e.row);
                    end
                end
                n_checks++;
                if (x_count !== 2'b10 || y_count !== 2'b01) begin
                    n_fail++;
                    $display("FAIL hs_code %0d: x_count=%b y_count=%b, required 10 01", hs, x_count, y_count);
                end
                hs++;
            end else if (req_valid) begin
                n_checks++;
                if (x_count !== 2'b01 || y_count !== 2'b01) begin
                    n_fail++;
                    $display("FAIL stall_code: x_count=%b y_count=%b, required 01 01", x_count, y_count);
                end
            end
            if (!stall) begin
                if (c == 80 || c == 161) begin
                    n_checks++;
                    if (x_count !== 2'b11 || y_count !== ((c == 80) ? 2'b00 : 2'b01)) begin
                        n_fail++;
                        $display("FAIL mb_step c=%0d: x_count=%b y_count=%b, required 11 %b",
                                 c, x_count, y_count, (c == 80) ? 2'b00 : 2'b01);
                    end
                end
                if (c == 162 || c == 163) begin
                    n_checks++;
                    if (x_count !== 2'b00 || y_count !== 2'b01 || req_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rewind c=%0d: x_count=%b y_count=%b valid=%b, required 00 01 0",
                                 c, x_count, y_count, req_valid);
                    end
                end
                if (c == 81 || c == 162 || c == 164) begin
                    n_checks++;
                    if (x !== ((c == 162) ? 32 : (c == 81) ? 16 : 0) || y !== ((c == 81) ? 0 : 16)) begin
                        n_fail++;
                        $display("FAIL boundary_xy c=%0d: x=%0d y=%0d, required %0d %0d", c, x, y,
                                 (c == 162) ? 32 : (c == 81) ? 16 : 0, (c == 81) ? 0 : 16);
                    end
                end
            end
            if (done) done_c = c;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        req_ready = 1'b0;
        n_checks++;
        if (done_c < 0) begin
            n_fail++;
            $display("FAIL scan_timeout: no done within %0d cycles, required done", c);
        end
        n_checks++;
        if (hs !== 256 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL hs_count: %0d handshakes (%0d left), required 256 (0 left)", hs, exp_q.size());
        end
        n_checks++;
        if (x !== W || y !== H) begin
            n_fail++;
            $display("FAIL end_xy: x=%0d y=%0d, required %0d %0d", x, y, W, H);
        end
        if (!stall) begin
            n_checks++;
            if (done_c !== 326) begin
                n_fail++;
                $display("FAIL done_latency: done at %0d, required 326", done_c);
            end
        end
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: done=%b busy=%b, required 0 0", done, busy);
        end
`ifdef SCAN_CHECK_EN
        n_checks++;
        if (chk_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_chk: chk_err=%b, required 0", chk_err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int  hs = 0;
        int  c = 0;
        bit  saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; req_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (hs < 100 && c < 2000) begin
            req_ready = ($urandom_range(0, 2) == 0);
            #1;
            if (req_valid && req_ready) hs++;
            if (done) saw_done = 1'b1;
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (hs !== 100) begin
            n_fail++;
            $display("FAIL mid_timeout: %0d handshakes, required 100", hs);
        end
        reset = 1'b1; req_ready = 1'b1;
        #1;
        if (done) saw_done = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || saw_done) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: valid=%b busy=%b done=%b seen_done=%b, required 0 0 0 0",
                     req_valid, busy, done, saw_done);
        end
        n_checks++;
        if (x_count !== 2'b01 || y_count !== 2'b01 || req_word !== 2'd0 || req_row !== 4'd0 ||
            mb_col !== 1'b0 || mb_row !== 1'b0 || x !== 0 || y !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_state: xc=%b yc=%b word=%0d row=%0d col=%0d mbrow=%0d x=%0d y=%0d, required 01 01 0 0 0 0 0 0",
                     x_count, y_count, req_word, req_row, mb_col, mb_row, x, y);
        end
        reset = 1'b0;
        req_ready = 1'b0;
    endtask

`ifdef SCAN_CHECK_EN
    task automatic test_chk_err();
        @(negedge clk);
        start = 1'b1; req_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        force_x16 = 1'b1;
        @(negedge clk);
        force_x16 = 1'b0;
        #1;
        n_checks++;
        if (chk_err !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_set: chk_err=%b, required 1", chk_err);
        end
        req_ready = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        n_checks++;
        if (chk_err !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_sticky: chk_err=%b, required 1", chk_err);
        end
        reset = 1'b1; req_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (chk_err !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_clear: chk_err=%b, required 0", chk_err);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; req_ready = 1'b0; force_x16 = 1'b0;
        n_checks = 0; n_fail = 0;
        test_reset();
        test_scan(1'b0);
        test_reset();
        test_scan(1'b1);
        test_reset();
        test_reset_mid();
        test_scan(1'b1);
`ifdef SCAN_CHECK_EN
        test_reset();
        test_chk_err();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mb_scan_ctrl.md
Name: mb_scan_ctrl

Overview:
- Control FSM directly upstream of the frame-scan datapath.
- Drives the datapath's 2-bit x_count/y_count step codes so that the datapath x/y pointer walks the frame macroblock by macroblock, raster order.
- Inside each 16x16 macroblock it walks row by row, 4 words of 4 pixels per row.
- Issues one pixel-word fetch request per word over a valid/ready handshake, and terminates on the datapath's stop flag.

Parameters:
- WIDTH, 352, frame width in pixels; multiple of 16.
- HEIGHT, 288, frame height in pixels; multiple of 16.
- MB_COLS, WIDTH/16, derived (localparam); macroblocks per row.
- MB_ROWS, HEIGHT/16, derived (localparam); macroblock rows.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a frame scan when idle
- stop  in  1  from datapath; set when x==WIDTH and y==HEIGHT
- x_16  in  1  from datapath; x%16==0
- y_16  in  1  from datapath; y%16==0
- x_count  out  2  to datapath; 00 x-=16, 01 hold, 10 x+=4, 11 x+=16
- y_count  out  2  to datapath; 00 y-=16, 01/10 hold, 11 y+=1
- req_valid  out  1  fetch request valid
- req_ready  in  1  fetch sink accepts
- req_word  out  2  word index in row, 0..3
- req_row  out  4  row index in macroblock, 0..15
- mb_col  out  $clog2(MB_COLS)  current macroblock column
- mb_row  out  $clog2(MB_ROWS)  current macroblock row
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: state IDLE; all counters 0; x_count=01; y_count=01; req_valid=0; busy=0; done=0. The datapath is reset by the same reset, so x=y=0.
- x_count/y_count are combinational from state and handshake; the datapath applies them at the next clk edge.
- Outside the cases below, codes are hold (01/01).
- IDLE: on start go to FETCH. start in any other state is ignored.
- FETCH:
  - req_valid=1.
  - On req_valid&&req_ready: x_count=10 (x+4) and req_word increments.
  - On acceptance with req_word==3: go to ROW_RET. At this point the datapath x = MB origin+16.
  - No acceptance: codes hold, indices unchanged.
- ROW_RET (1 cycle):
  - x_count=00, y_count=11. Moves x back to the MB origin, y down one row.
  - If req_row<15: req_row++, go to FETCH.
  - Else: req_row=0, go to MB_NEXT if mb_col<MB_COLS-1, otherwise END_COL.
- MB_NEXT (1 cycle): x_count=11, y_count=00; mb_col++; go to FETCH.
- END_COL (1 cycle):
  - x_count=11, y_count=01. Leaves x=WIDTH, y=16*(mb_row+1).
  - If mb_row==MB_ROWS-1: go to DONE.
  - Else: mb_row++, mb_col=0, go to REWIND.
- REWIND: x_count=00 for exactly MB_COLS cycles (internal counter) to bring x to 0; then go to FETCH.
- DONE:
  - Wait for stop==1.
  - The cycle stop is seen: done=1 for one cycle, go to IDLE.
- Cycle count with req_ready held high: 81 cycles per MB, plus MB_COLS per rewind. 352x288 gives 32450 cycles from start to DONE.
- reset mid-scan: immediate return to reset values; no done pulse.
- All counters wrap only under FSM control; no free-running overflow.

Optional Feature:
- Macro SCAN_CHECK_EN.
- Defined:
  - Adds output chk_err (1 bit), sticky until reset.
  - chk_err is set if x_16 is 0 while in FETCH with req_word==0.
  - chk_err is set if y_16 is 0 while entering FETCH with req_row==0.
  - chk_err is set if stop is 1 before DONE.
- Not defined: no chk_err port; x_16/y_16 unused; stop sampled only in DONE.

Decomposition:
- Shared package scan_pkg:
  - X_SUB16/X_HOLD/X_ADD4/X_ADD16 and Y_SUB16/Y_HOLD/Y_ADD1 2-bit code constants.
  - State enum scan_state_t (IDLE, FETCH, ROW_RET, MB_NEXT, END_COL, REWIND, DONE).
- No sub-module; counters and FSM live in one module.

Test Plan:
- WIDTH=HEIGHT=32, start pulse, req_ready=1:
  - Exactly 256 req handshakes.
  - done 326 cycles after DONE entry path (pipelined datapath stop=1).
  - Datapath ends x=32, y=32.
- Same config, req_ready toggled 1-of-3 cycles: identical (req_row, req_word, mb_col, mb_row) sequence; no x step on stalled cycles.
- Check first MB boundary: after 80 handshake/return cycles, MB_NEXT drives x_count=11, y_count=00; datapath x=16, y=0.
- Row end: END_COL then 2 REWIND cycles with x_count=00; datapath x=0, y=16.
- reset asserted at handshake 100: all outputs return to reset values next cycle; new start rescans from word 0.
- SCAN_CHECK_EN, force x_16=0 in FETCH word 0: chk_err=1 and stays 1 until reset.
